edge_frame_writer: RTL and testbench

Output-side frame assembler for the edge-detection pipeline. It accepts the stream of interior edge pixels produced by the Prewitt/Sobel datapath, (WIDTH-2)×(HEIGHT-2) pixels in raster order, and writes each one to its correct address in a WIDTH×HEIGHT frame buffer. Once the frame is complete, it drains the full frame in raster order over a valid/ready read port, forcing the one-pixel border to 0. It is the consumer end of the edge-pixel interface and the producer for the hex dump or downstream scanner stages.

---
 rtl/edge_pkg.sv | 7 +
 rtl/frame_ram.sv | 29 ++
 rtl/edge_frame_writer.sv | 175 +++++++++++++++++
 tb/tb_edge_frame_writer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared types and constants for the edge-detection pipeline
// (datapath and frame writer).
package edge_pkg;
  localparam int PIX_W_DEF = 8;
  typedef logic [PIX_W_DEF-1:0] pixel_t;
  typedef enum logic {ACCEPT, DRAIN} writer_state_t;
endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame store: synchronous write, registered 1-cycle read, no reset.
// The read register holds its value whenever rd_en_i is low.
module frame_ram #(
  parameter int DEPTH  = 25,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [PIX_W-1:0]  wr_dat_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [PIX_W-1:0]  rd_dat_o
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [PIX_W-1:0] rd_q;

  // Out-of-range addresses are dropped so only the low index bits reach the array.
  always_ff @(posedge clk) begin
    if (wr_en_i && (wr_addr_i < DEPTH_A)) mem_q[wr_addr_i[IDX_W-1:0]] <= wr_dat_i;
    if (rd_en_i && (rd_addr_i < DEPTH_A)) rd_q <= mem_q[rd_addr_i[IDX_W-1:0]];
  end

  assign rd_dat_o = rd_q;
endmodule

// File: rtl/edge_frame_writer.sv
// Scatters interior edge pixels into a WIDTH x HEIGHT frame, then drains it in raster order
// with a zero border; 1 px/cycle each way, first drain beat 2 cycles after last accept, rd_ready stalls drain losslessly.
module edge_frame_writer
  import edge_pkg::*;
#(
  parameter int WIDTH  = 45,
  parameter int HEIGHT = 45,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int ADDR_W = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_last,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [PIX_W-1:0] rd_pixel,
  output logic             rd_last,
  output logic             frame_done,
  output logic             err
);
  localparam int N = (WIDTH - 2) * (HEIGHT - 2);
  localparam int F = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] N_LAST   = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] F_LAST   = ADDR_W'(F - 1);
  localparam logic [ADDR_W-1:0] WR_FIRST = ADDR_W'(WIDTH + 1);
  localparam logic [ADDR_W-1:0] COL_IN_L = ADDR_W'(WIDTH - 2);
  localparam logic [ADDR_W-1:0] COL_L    = ADDR_W'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] ROW_L    = ADDR_W'(HEIGHT - 1);

  writer_state_t     state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, wr_col_q, wr_col_d, wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, rd_row_q, rd_row_d, rd_col_q, rd_col_d;
  logic              issue_q, issue_d, err_q, err_d;
  logic              s1_vld_q, s1_vld_d, s1_border_q, s1_border_d, s1_last_q, s1_last_d;
  logic              rd_vld_q, rd_vld_d, rd_last_q, rd_last_d;
  logic [PIX_W-1:0]  rd_pix_q, rd_pix_d, ram_rdata;
  logic              wr_fire, rd_fire, adv, done, n_hit, border;

  assign in_ready   = (state_q == ACCEPT);
  assign wr_fire    = in_valid && in_ready;
  assign adv        = !rd_vld_q || rd_ready;
  assign rd_fire    = (state_q == DRAIN) && issue_q && adv;
  assign done       = rd_vld_q && rd_ready && rd_last_q;
  assign n_hit      = (wr_cnt_q == N_LAST);
  assign border     = (rd_row_q == '0) || (rd_row_q == ROW_L) ||
                      (rd_col_q == '0) || (rd_col_q == COL_L);

  assign rd_valid   = rd_vld_q;
  assign rd_pixel   = rd_pix_q;
  assign rd_last    = rd_last_q;
  assign frame_done = done;
  assign err        = err_q;

  frame_ram #(.DEPTH(F), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_fire),
    .wr_addr_i (wr_addr_q),
    .wr_dat_i  (in_pixel),
    .rd_en_i   (rd_fire),
    .rd_addr_i (rd_addr_q),
    .rd_dat_o  (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    wr_col_d    = wr_col_q;
    wr_cnt_d    = wr_cnt_q;
    rd_addr_d   = rd_addr_q;
    rd_row_d    = rd_row_q;
    rd_col_d    = rd_col_q;
    issue_d     = issue_q;
    err_d       = err_q;
    s1_vld_d    = s1_vld_q;
    s1_border_d = s1_border_q;
    s1_last_d   = s1_last_q;
    rd_vld_d    = rd_vld_q;
    rd_pix_d    = rd_pix_q;
    rd_last_d   = rd_last_q;
    case (state_q)
      ACCEPT: begin
        if (wr_fire) begin
          if (in_last || n_hit) begin
            state_d   = DRAIN;
            issue_d   = 1'b1;
            rd_addr_d = '0;
            rd_row_d  = '0;
            rd_col_d  = '0;
            if (in_last != n_hit) err_d = 1'b1;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            // Skip the right border of this row and the left border of the next.
            if (wr_col_q == COL_IN_L) begin
              wr_col_d  = ADDR_W'(1);
              wr_addr_d = wr_addr_q + ADDR_W'(3);
            end else begin
              wr_col_d  = wr_col_q + 1'b1;
              wr_addr_d = wr_addr_q + 1'b1;
            end
          end
        end
      end
      DRAIN: begin
        // RAM read stage and output register advance together, so a stall freezes both.
        if (adv) begin
          s1_vld_d    = rd_fire;
          s1_border_d = border;
          s1_last_d   = rd_fire && (rd_addr_q == F_LAST);
          rd_vld_d    = s1_vld_q;
          rd_last_d   = s1_vld_q && s1_last_q;
          if (s1_vld_q) rd_pix_d = s1_border_q ? '0 : ram_rdata;
        end
        if (rd_fire) begin
          if (rd_addr_q == F_LAST) begin
            issue_d = 1'b0;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
            if (rd_col_q == COL_L) begin
              rd_col_d = '0;
              rd_row_d = rd_row_q + 1'b1;
            end else begin
              rd_col_d = rd_col_q + 1'b1;
            end
          end
        end
        if (done) begin
          state_d   = ACCEPT;
          wr_addr_d = WR_FIRST;
          wr_col_d  = ADDR_W'(1);
          wr_cnt_d  = '0;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ACCEPT;
      wr_addr_q   <= WR_FIRST;
      wr_col_q    <= ADDR_W'(1);
      wr_cnt_q    <= '0;
      rd_addr_q   <= '0;
      rd_row_q    <= '0;
      rd_col_q    <= '0;
      issue_q     <= 1'b0;
      err_q       <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_border_q <= 1'b0;
      s1_last_q   <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_pix_q    <= '0;
      rd_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      wr_col_q    <= wr_col_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_addr_q   <= rd_addr_d;
      rd_row_q    <= rd_row_d;
      rd_col_q    <= rd_col_d;
      issue_q     <= issue_d;
      err_q       <= err_d;
      s1_vld_q    <= s1_vld_d;
      s1_border_q <= s1_border_d;
      s1_last_q   <= s1_last_d;
      rd_vld_q    <= rd_vld_d;
      rd_pix_q    <= rd_pix_d;
      rd_last_q   <= rd_last_d;
    end
  end
endmodule

// File: tb/tb_edge_frame_writer.sv
// Randomized self-checking bench for edge_frame_writer on a 5x5 frame against a
// coordinate-based frame model.
module tb_edge_frame_writer;
  localparam int W = 5;
  localparam int H = 5;
  localparam int N = (W - 2) * (H - 2);
  localparam int F = W * H;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_last;
  logic [7:0] in_pixel;
  logic       rd_valid, rd_ready, rd_last, frame_done, err;
  logic [7:0] rd_pixel;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int acc_cnt  = 0;
  int mem_m [F];
  int exp_f [F];
  int wk = 0;
  int lat, span, d0, a0;

  edge_frame_writer #(.WIDTH(W), .HEIGHT(H), .PIX_W(8), .ADDR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .in_last    (in_last),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_pixel   (rd_pixel),
    .rd_last    (rd_last),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (in_valid && in_ready && rst) acc_cnt++;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // k-th interior pixel of a frame sits at row k/(W-2)+1, column k%(W-2)+1.
  function automatic int int_addr(input int k);
    return (k / (W - 2) + 1) * W + (k % (W - 2)) + 1;
  endfunction

  function automatic void build_expect();
    for (int a = 0; a < F; a++) begin
      if (a / W == 0 || a / W == H - 1 || a % W == 0 || a % W == W - 1) exp_f[a] = 0;
      else exp_f[a] = mem_m[a];
    end
  endfunction

  task automatic push(input logic [7:0] pix, input bit last, input bit gap);
    int t = 0;
    if (gap) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1; in_pixel = pix; in_last = last;
    while (!in_ready && t < 500) begin @(posedge clk); #1; t++; end
    chk_eq("push_wait", t < 500, 1);
    @(posedge clk); #1;
    mem_m[int_addr(wk)] = pix;
    wk++;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // pat: 0 = always ready, 1 = toggling, 2 = random.
  task automatic drain(input int pat, input int nbeats, output int lat_o, output int span_o);
    int beat = 0, cyc = 0, first = 0;
    bit stalled = 1'b0;
    logic [7:0] hold;
    lat_o = -1; span_o = -1; hold = '0;
    while (beat < nbeats && cyc < 2000) begin
      case (pat)
        0:       rd_ready = 1'b1;
        1:       rd_ready = cyc[0];
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk); cyc++;
      if (rd_valid && lat_o < 0) lat_o = cyc;
      if (stalled) begin
        chk_eq("stall_vld", rd_valid, 1);
        chk_eq("stall_pix", rd_pixel, hold);
      end
      if (rd_valid && rd_ready) begin
        chk_eq($sformatf("pix%0d", beat), rd_pixel, exp_f[beat]);
        chk_eq("rd_last", rd_last, beat == F - 1);
        chk_eq("frame_done", frame_done, beat == F - 1);
        if (beat == 0) first = cyc;
        if (beat == F - 1) span_o = cyc - first;
        beat++;
      end
      stalled = rd_valid && !rd_ready;
      hold = rd_pixel;
      @(posedge clk); #1;
    end
    chk_eq("drain_beats", beat, nbeats);
    rd_ready = 1'b0;
  endtask

  task automatic post_frame(input int d_before);
    chk_eq("post_rd_valid", rd_valid, 0);
    chk_eq("post_in_ready", in_ready, 1);
    chk_eq("done_once", done_cnt - d_before, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < F; i++) mem_m[i] = 0;
    rst = 1'b0; in_valid = 1'b0; in_pixel = '0; in_last = 1'b0; rd_ready = 1'b0;
    #12 rst = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset mid-clock after a partial frame.
    wk = 0;
    push(8'd1, 1'b0, 1'b0);
    push(8'd2, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk_eq("rst_in_ready", in_ready, 1);
    chk_eq("rst_rd_valid", rd_valid, 0);
    chk_eq("rst_rd_pixel", rd_pixel, 0);
    chk_eq("rst_rd_last", rd_last, 0);
    chk_eq("rst_frame_done", frame_done, 0);
    chk_eq("rst_err", err, 0);
    @(negedge clk) rst = 1'b1;
    wk = 0;

    // Nominal frame, rd_ready held high.
    for (int k = 1; k <= N; k++) push(8'(k), k == N, 1'b0);
    chk_eq("nom_in_ready", in_ready, 0);
    build_expect();
    d0 = done_cnt;
    drain(0, F, lat, span);
    chk_eq("nom_latency", lat, 3);
    chk_eq("nom_span", span, F - 1);
    post_frame(d0);
    chk_eq("nom_err", err, 0);

    // Toggling backpressure on the same frame.
    wk = 0;
    for (int k = 1; k <= N; k++) push(8'(k), k == N, 1'b0);
    build_expect();
    d0 = done_cnt;
    drain(1, F, lat, span);
    post_frame(d0);

    // Random pixels with input gaps and random backpressure.
    for (int r = 0; r < 3; r++) begin
      wk = 0;
      for (int k = 1; k <= N; k++) push(8'($urandom_range(1, 255)), k == N, 1'b1);
      build_expect();
      d0 = done_cnt;
      drain(2, F, lat, span);
      post_frame(d0);
      chk_eq("rand_err", err, 0);
    end

    // Early in_last: remaining interior addresses drain the previous frame's contents.
    wk = 0;
    for (int k = 1; k <= 5; k++) push(8'(k), k == 5, 1'b0);
    chk_eq("early_err", err, 1);
    chk_eq("early_in_ready", in_ready, 0);
    build_expect();
    d0 = done_cnt;
    drain(0, F, lat, span);
    post_frame(d0);

    // Missing in_last: a 10th pixel must wait until the drain completes.
    wk = 0;
    for (int k = 0; k < N; k++) push(8'(31 + k), 1'b0, 1'b0);
    chk_eq("miss_err", err, 1);
    chk_eq("miss_in_ready", in_ready, 0);
    build_expect();
    in_valid = 1'b1; in_pixel = 8'd99; in_last = 1'b0;
    a0 = acc_cnt;
    d0 = done_cnt;
    drain(1, F, lat, span);
    chk_eq("miss_no_accept", acc_cnt - a0, 0);
    post_frame(d0);
    wk = 0;
    push(8'd99, 1'b0, 1'b0);
    for (int k = 1; k < N; k++) push(8'(99 + k), k == N - 1, 1'b0);
    build_expect();
    d0 = done_cnt;
    drain(0, F, lat, span);
    post_frame(d0);

    // Reset at drain beat 10.
    wk = 0;
    for (int k = 0; k < N; k++) push(8'(51 + k), k == N - 1, 1'b0);
    build_expect();
    drain(0, 10, lat, span);
    #2 rst = 1'b0;
    #1;
    chk_eq("mid_rst_rd_valid", rd_valid, 0);
    chk_eq("mid_rst_err", err, 0);
    @(negedge clk) rst = 1'b1;
    #1;
    chk_eq("mid_rst_in_ready", in_ready, 1);
    chk_eq("mid_rst_rd_valid2", rd_valid, 0);
    wk = 0;

    // Back-to-back frames.
    for (int f = 0; f < 2; f++) begin
      wk = 0;
      for (int k = 0; k < N; k++) push(8'(10 + 10 * f + k), k == N - 1, 1'b0);
      build_expect();
      d0 = done_cnt;
      drain(0, F, lat, span);
      chk_eq("b2b_latency", lat, 3);
      post_frame(d0);
      chk_eq("b2b_err", err, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
